// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential double-dabble binary-to-BCD converter. One bit of the captured
// operand is shifted into the BCD register per clock. Before every shift, each
// 4-bit digit gets the add-3 correction. A conversion takes WIDTH shift cycles.
// The result lands on bcd_out on the same edge that raises the one-cycle done
// pulse.
//
// Parameters
//   WIDTH   binary operand width (>= 1)
//   DIGITS  number of packed BCD digits on bcd_out (4 bits each)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   start    in   conversion request; only looked at while idle
//   bin_in   in   [WIDTH-1:0] unsigned operand, captured on an accepted start
//   busy     out  high while shifting
//   done     out  one-cycle completion pulse
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, digit 0 (ones) in [3:0]; holds
//                 the last result until the next completion
//   ovf      out  only when BCD_OVERFLOW_EN is defined: set when the operand
//                 did not fit in DIGITS decimal digits; registered with done
//
// Optional feature macro: BCD_OVERFLOW_EN (adds the ovf port and carry-out
// tracking). Without it, results are still truncated to value mod 10^DIGITS.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_OVERFLOW_EN
   ,
   output logic                  ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   bin_sr;
   logic [BCD_W-1:0]   bcd_sr;
   logic [CNT_W-1:0]   cnt;

   logic [BCD_W-1:0]   bcd_adj;      // bcd_sr after per-digit correction
   logic [BCD_W-1:0]   bcd_shifted;  // corrected digits shifted left by one
   logic               last_shift;

`ifdef BCD_OVERFLOW_EN
   logic               carry_out;    // bit leaving the top digit this cycle
   logic               ovf_acc;      // sticky carry-out over the conversion
`endif

   // Add-3 correction for one digit. Codes 10..15 never occur in a legal
   // conversion. They are forced to zero so a corrupted digit cannot propagate
   // a bogus carry.
   function automatic logic [3:0] dab_fix(input logic [3:0] d);
      if (d <= 4'd4) begin
         return d;
      end else if (d <= 4'd9) begin
         return d + 4'd3;
      end else begin
         return 4'd0;
      end
   endfunction

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = dab_fix(bcd_sr[4*gi +: 4]);
   end

   // The corrected MSB of the top digit falls off the end. That drop is the
   // mod 10^DIGITS truncation.
   assign bcd_shifted = BCD_W'({bcd_adj, bin_sr[WIDTH-1]});
   assign last_shift  = (cnt == CNT_W'(WIDTH - 1));

`ifdef BCD_OVERFLOW_EN
   // A 1 leaving the top digit means the running value reached 10^DIGITS.
   // This happens iff the operand exceeds 10^DIGITS-1.
   assign carry_out = bcd_adj[BCD_W-1];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bin_sr  <= '0;
         bcd_sr  <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
`ifdef BCD_OVERFLOW_EN
         ovf_acc <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr  <= bin_in;
                  bcd_sr  <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
`ifdef BCD_OVERFLOW_EN
                  ovf_acc <= 1'b0;
`endif
               end
            end

            SHIFT: begin
               bcd_sr <= bcd_shifted;
               bin_sr <= bin_sr << 1;
               cnt    <= cnt + CNT_W'(1);
`ifdef BCD_OVERFLOW_EN
               ovf_acc <= ovf_acc | carry_out;
`endif
               if (last_shift) begin
                  // Publish the result on the same edge as the done pulse.
                  // The FSM returns to IDLE, so a start in the done cycle
                  // is accepted immediately.
                  bcd_out <= bcd_shifted;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
`ifdef BCD_OVERFLOW_EN
                  ovf     <= ovf_acc | carry_out;
`endif
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
